// File: rtl/uart_rx.sv
// uart_rx: UART receiver, 8N1 by default. Defining UART_RX_PARITY_EN
// switches it to 8E1 and adds a parity_error output.
//
// The asynchronous rx_pin passes through a two-flop synchronizer. The
// start bit is confirmed at mid-bit. Data bits (and the parity bit, when
// enabled) are then sampled once per bit period, LSB first. A good frame
// is handed to a one-entry holding register with a valid/ready handshake.
//
// Parameters:
//   UART_CLK_HZ    system clock frequency in Hz
//   BAUD_RATE      line bit rate; CLKS_PER_BIT = UART_CLK_HZ / BAUD_RATE (>= 4)
//
// Ports:
//   clk            system clock, rising edge
//   rst            synchronous active-high reset
//   rx_pin         asynchronous serial line, idle high
//   rx_data        received byte, stable while rx_data_valid=1
//   rx_data_valid  holding register full
//   rx_data_ready  consumer accepts (transfer when valid & ready)
//   frame_error    1-cycle pulse: stop bit sampled low
//   overrun        1-cycle pulse: byte lost because the holding register was full
//   parity_error   1-cycle pulse: parity mismatch (only with UART_RX_PARITY_EN)
module uart_rx #(
   parameter int UART_CLK_HZ = 27000000,
   parameter int BAUD_RATE   = 115200
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_pin,
   output logic [7:0] rx_data,
   output logic       rx_data_valid,
   input  logic       rx_data_ready,
   output logic       frame_error,
   output logic       overrun
`ifdef UART_RX_PARITY_EN
   ,
   output logic       parity_error
`endif
);

   localparam int CLKS_PER_BIT = UART_CLK_HZ / BAUD_RATE;
   localparam int CNT_W        = (CLKS_PER_BIT < 4) ? 2 : $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

   generate
      if (CLKS_PER_BIT < 4) begin : g_bad_cfg
         $error("uart_rx: UART_CLK_HZ / BAUD_RATE must be at least 4");
      end
   endgenerate

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

   state_t           state, state_nxt;
   logic             sync1, rx_s;
   logic [CNT_W-1:0] bit_cnt, cnt_nxt;
   logic [2:0]       bit_idx, idx_nxt;
   logic [7:0]       shift, shift_nxt;
   logic             stop_ok, stop_bad;
   logic             par_fail;
   logic             deliver;

`ifdef UART_RX_PARITY_EN
   logic par_bit, par_nxt;
   // Even parity: data bits plus parity bit must XOR to zero.
   assign par_fail = (^shift) ^ par_bit;
`else
   assign par_fail = 1'b0;
`endif

   assign deliver = stop_ok & ~par_fail;

   // Next-state and bit-timing logic
   always_comb begin
      state_nxt = state;
      cnt_nxt   = bit_cnt;
      idx_nxt   = bit_idx;
      shift_nxt = shift;
      stop_ok   = 1'b0;
      stop_bad  = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_nxt   = par_bit;
`endif
      case (state)
         IDLE: begin
            if (!rx_s) begin
               state_nxt = START;
               cnt_nxt   = '0;
            end
         end
         START: begin
            // Half a bit in: a line that is high again was only a glitch.
            if (bit_cnt == CNT_HALF) begin
               cnt_nxt   = '0;
               idx_nxt   = 3'd0;
               state_nxt = rx_s ? IDLE : DATA;
            end else begin
               cnt_nxt = bit_cnt + CNT_W'(1);
            end
         end
         DATA: begin
            if (bit_cnt == CNT_LAST) begin
               cnt_nxt            = '0;
               shift_nxt[bit_idx] = rx_s;
               idx_nxt            = bit_idx + 3'd1;
               if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_nxt = PARITY;
`else
                  state_nxt = STOP;
`endif
               end
            end else begin
               cnt_nxt = bit_cnt + CNT_W'(1);
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (bit_cnt == CNT_LAST) begin
               cnt_nxt   = '0;
               par_nxt   = rx_s;
               state_nxt = STOP;
            end else begin
               cnt_nxt = bit_cnt + CNT_W'(1);
            end
         end
`endif
         STOP: begin
            // Leaving at mid-stop-bit lets an immediately following start
            // bit be caught on its falling edge.
            if (bit_cnt == CNT_LAST) begin
               cnt_nxt = '0;
               if (rx_s) begin
                  stop_ok   = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  stop_bad  = 1'b1;
                  state_nxt = BREAK;
               end
            end else begin
               cnt_nxt = bit_cnt + CNT_W'(1);
            end
         end
         BREAK: begin
            // A held-low line reports one frame error, then waits for idle.
            if (rx_s) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Synchronizer, counters, holding register and status pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1         <= 1'b1;
         rx_s          <= 1'b1;
         bit_cnt       <= '0;
         bit_idx       <= 3'd0;
         rx_data       <= 8'd0;
         rx_data_valid <= 1'b0;
         frame_error   <= 1'b0;
         overrun       <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_error  <= 1'b0;
`endif
      end else begin
         sync1       <= rx_pin;
         rx_s        <= sync1;
         bit_cnt     <= cnt_nxt;
         bit_idx     <= idx_nxt;
         frame_error <= stop_bad;
         overrun     <= deliver & rx_data_valid & ~rx_data_ready;
`ifdef UART_RX_PARITY_EN
         parity_error <= stop_ok & par_fail;
`endif
         // A consume on the same edge frees the slot for the new byte.
         if (deliver && (!rx_data_valid || rx_data_ready)) begin
            rx_data       <= shift;
            rx_data_valid <= 1'b1;
         end else if (rx_data_valid && rx_data_ready) begin
            rx_data_valid <= 1'b0;
         end
      end
   end

   // Shift register carries only data; every bit is rewritten per frame.
   always_ff @(posedge clk) begin
      shift <= shift_nxt;
`ifdef UART_RX_PARITY_EN
      par_bit <= par_nxt;
`endif
   end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx at 10 clocks per bit.
// Frames are driven from tasks on the falling clock edge; a monitor
// records handshakes and status pulses half a cycle away from the
// active edge. Honours UART_RX_PARITY_EN like the design.
module tb_uart_rx;

   localparam int CLK_HZ = 1000000;
   localparam int BAUD   = 100000;
   localparam int CPB    = CLK_HZ / BAUD;
`ifdef UART_RX_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif
   // Bit periods before the stop bit: start + 8 data (+ parity).
   localparam int NB = PAR_EN ? 10 : 9;
   // Edges from the first start-bit edge to the mid-start sample:
   // 2 synchronizer + 1 IDLE->START + CPB/2 half-bit count.
   localparam int SAMPLE_OFS = 3 + CPB / 2;
   localparam int STOP_EDGE  = SAMPLE_OFS + NB * CPB;
   // Stop-bit negedge index that puts ready=1 on the stop sample edge.
   localparam int READY_J = SAMPLE_OFS - 1;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx_pin = 1'b1;
   logic       rx_data_ready = 1'b0;
   logic [7:0] rx_data;
   logic       rx_data_valid;
   logic       frame_error;
   logic       overrun;
`ifdef UART_RX_PARITY_EN
   logic       parity_error;
   int         pe_cnt = 0;
   int         pe_cyc = -1;
`endif

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int fe_cnt = 0;
   int ov_cnt = 0;
   int fe_cyc = -1;
   int ov_cyc = -1;
   int rise_cyc = -1;
   logic prev_valid = 1'b0;
   logic [7:0] acc_q[$];

   uart_rx #(.UART_CLK_HZ(CLK_HZ), .BAUD_RATE(BAUD)) dut (
      .clk(clk),
      .rst(rst),
      .rx_pin(rx_pin),
      .rx_data(rx_data),
      .rx_data_valid(rx_data_valid),
      .rx_data_ready(rx_data_ready),
      .frame_error(frame_error),
      .overrun(overrun)
`ifdef UART_RX_PARITY_EN
      ,
      .parity_error(parity_error)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Values seen here are the ones present at the next rising edge.
   always @(negedge clk) begin
      #1;
      if (frame_error === 1'b1) begin fe_cnt <= fe_cnt + 1; fe_cyc <= cyc; end
      if (overrun === 1'b1) begin ov_cnt <= ov_cnt + 1; ov_cyc <= cyc; end
`ifdef UART_RX_PARITY_EN
      if (parity_error === 1'b1) begin pe_cnt <= pe_cnt + 1; pe_cyc <= cyc; end
`endif
      if (rx_data_valid === 1'b1 && prev_valid !== 1'b1) rise_cyc <= cyc;
      prev_valid <= rx_data_valid;
      if (rx_data_valid === 1'b1 && rx_data_ready === 1'b1) acc_q.push_back(rx_data);
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Drives one frame. ready is pulsed for one cycle at stop-bit negedge ready_j.
   task automatic send_frame(input logic [7:0] b, input logic stop, input logic par_flip,
                             input int ready_j, output int start);
      start = cyc;
      rx_pin = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx_pin = b[i];
         repeat (CPB) @(negedge clk);
      end
      if (PAR_EN) begin
         rx_pin = (^b) ^ par_flip;
         repeat (CPB) @(negedge clk);
      end
      rx_pin = stop;
      for (int j = 1; j <= CPB; j++) begin
         @(negedge clk);
         if (j == ready_j) rx_data_ready = 1'b1;
         else if (j == ready_j + 1) rx_data_ready = 1'b0;
      end
   endtask

   task automatic consume;
      rx_data_ready = 1'b1;
      @(negedge clk);
      rx_data_ready = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      idle(3);
      checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %0h expected 0", rx_data); end
      checks++; if (rx_data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", rx_data_valid); end
      checks++; if (frame_error !== 1'b0) begin errors++; $display("FAIL reset_frame_error: got %b expected 0", frame_error); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
      rst = 1'b0;
      idle(5);
   endtask

   task automatic test_single;
      int s;
      acc_q.delete();
      send_frame(8'hA5, 1'b1, 1'b0, -10, s);
      idle(5);
      checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL single_data: got %0h expected a5", rx_data); end
      checks++; if (rx_data_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", rx_data_valid); end
      checks++; if (rise_cyc != s + STOP_EDGE) begin errors++; $display("FAIL single_latency: got cycle %0d expected %0d", rise_cyc, s + STOP_EDGE); end
      idle(20);
      checks++; if (rx_data_valid !== 1'b1) begin errors++; $display("FAIL single_hold: got %b expected 1", rx_data_valid); end
      consume();
      checks++; if (rx_data_valid !== 1'b0) begin errors++; $display("FAIL single_consume_valid: got %b expected 0", rx_data_valid); end
      checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL single_consume_data: got %0h expected a5", rx_data); end
      checks++; if (acc_q.size() != 1 || acc_q[0] !== 8'hA5) begin errors++; $display("FAIL single_transfer: got %0d transfers expected 1 of a5", acc_q.size()); end
   endtask

   task automatic test_overrun;
      int s1, s2, ov0;
      ov0 = ov_cnt;
      send_frame(8'h3C, 1'b1, 1'b0, -10, s1);
      send_frame(8'hC3, 1'b1, 1'b0, -10, s2);
      idle(5);
      checks++; if (rx_data !== 8'h3C) begin errors++; $display("FAIL overrun_data: got %0h expected 3c", rx_data); end
      checks++; if (rx_data_valid !== 1'b1) begin errors++; $display("FAIL overrun_valid: got %b expected 1", rx_data_valid); end
      checks++; if (ov_cnt - ov0 != 1) begin errors++; $display("FAIL overrun_count: got %0d expected 1", ov_cnt - ov0); end
      checks++; if (ov_cyc != s2 + STOP_EDGE) begin errors++; $display("FAIL overrun_cycle: got %0d expected %0d", ov_cyc, s2 + STOP_EDGE); end
      consume();
   endtask

   task automatic test_ready_on_delivery;
      int s1, s2, ov0;
      ov0 = ov_cnt;
      acc_q.delete();
      send_frame(8'h3C, 1'b1, 1'b0, -10, s1);
      send_frame(8'hC3, 1'b1, 1'b0, READY_J, s2);
      idle(5);
      checks++; if (rx_data !== 8'hC3) begin errors++; $display("FAIL rod_data: got %0h expected c3", rx_data); end
      checks++; if (rx_data_valid !== 1'b1) begin errors++; $display("FAIL rod_valid: got %b expected 1", rx_data_valid); end
      checks++; if (ov_cnt != ov0) begin errors++; $display("FAIL rod_overrun: got %0d pulses expected 0", ov_cnt - ov0); end
      checks++; if (acc_q.size() != 1 || acc_q[0] !== 8'h3C) begin errors++; $display("FAIL rod_first_transfer: got %0d transfers expected 1 of 3c", acc_q.size()); end
      consume();
      checks++; if (acc_q.size() != 2 || acc_q[acc_q.size()-1] !== 8'hC3) begin errors++; $display("FAIL rod_second_transfer: got %0d transfers expected 2 ending c3", acc_q.size()); end
   endtask

   task automatic test_frame_error;
      int s, fe0;
      fe0 = fe_cnt;
      acc_q.delete();
      send_frame(8'h55, 1'b0, 1'b0, -10, s);
      idle(30);
      rx_pin = 1'b1;
      idle(20);
      checks++; if (fe_cnt - fe0 != 1) begin errors++; $display("FAIL fe_count: got %0d expected 1", fe_cnt - fe0); end
      checks++; if (fe_cyc != s + STOP_EDGE) begin errors++; $display("FAIL fe_cycle: got %0d expected %0d", fe_cyc, s + STOP_EDGE); end
      checks++; if (rx_data_valid !== 1'b0) begin errors++; $display("FAIL fe_discard: got valid %b expected 0", rx_data_valid); end
      send_frame(8'h01, 1'b1, 1'b0, -10, s);
      idle(5);
      checks++; if (rx_data !== 8'h01 || rx_data_valid !== 1'b1) begin errors++; $display("FAIL fe_recover: got %0h valid %b expected 01 valid 1", rx_data, rx_data_valid); end
      consume();
      checks++; if (acc_q.size() != 1 || fe_cnt - fe0 != 1) begin errors++; $display("FAIL fe_after: got %0d transfers %0d errors expected 1 and 1", acc_q.size(), fe_cnt - fe0); end
   endtask

   task automatic test_glitch;
      int s, fe0, ov0;
      fe0 = fe_cnt;
      ov0 = ov_cnt;
      rx_pin = 1'b0;
      idle(3);
      rx_pin = 1'b1;
      idle(40);
      checks++; if (rx_data_valid !== 1'b0) begin errors++; $display("FAIL glitch_valid: got %b expected 0", rx_data_valid); end
      checks++; if (fe_cnt != fe0 || ov_cnt != ov0) begin errors++; $display("FAIL glitch_pulses: got fe %0d ov %0d expected 0 0", fe_cnt - fe0, ov_cnt - ov0); end
      send_frame(8'h5A, 1'b1, 1'b0, -10, s);
      idle(5);
      checks++; if (rx_data !== 8'h5A || rx_data_valid !== 1'b1) begin errors++; $display("FAIL glitch_next: got %0h valid %b expected 5a valid 1", rx_data, rx_data_valid); end
      consume();
   endtask

   task automatic test_reset_mid;
      int s, fe0;
      fe0 = fe_cnt;
      rx_pin = 1'b0;
      idle(CPB);
      rx_pin = 1'b1;
      idle(3 * CPB);
      rst = 1'b1;
      idle(2);
      checks++; if (rx_data !== 8'h00 || rx_data_valid !== 1'b0) begin errors++; $display("FAIL rstmid_outputs: got %0h valid %b expected 00 valid 0", rx_data, rx_data_valid); end
      checks++; if (frame_error !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL rstmid_pulses: got fe %b ov %b expected 0 0", frame_error, overrun); end
      rst = 1'b0;
      idle(8 * CPB);
      checks++; if (rx_data_valid !== 1'b0 || fe_cnt != fe0) begin errors++; $display("FAIL rstmid_abandon: got valid %b fe %0d expected 0 0", rx_data_valid, fe_cnt - fe0); end
      send_frame(8'h81, 1'b1, 1'b0, -10, s);
      idle(5);
      checks++; if (rx_data !== 8'h81 || rx_data_valid !== 1'b1) begin errors++; $display("FAIL rstmid_next: got %0h valid %b expected 81 valid 1", rx_data, rx_data_valid); end
      consume();
   endtask

`ifdef UART_RX_PARITY_EN
   task automatic test_parity;
      int s, pe0;
      pe0 = pe_cnt;
      send_frame(8'h07, 1'b1, 1'b0, -10, s);
      idle(5);
      checks++; if (rx_data !== 8'h07 || rx_data_valid !== 1'b1) begin errors++; $display("FAIL parity_good: got %0h valid %b expected 07 valid 1", rx_data, rx_data_valid); end
      checks++; if (pe_cnt != pe0) begin errors++; $display("FAIL parity_good_pulse: got %0d expected 0", pe_cnt - pe0); end
      consume();
      send_frame(8'h07, 1'b1, 1'b1, -10, s);
      idle(5);
      checks++; if (rx_data_valid !== 1'b0) begin errors++; $display("FAIL parity_bad_valid: got %b expected 0", rx_data_valid); end
      checks++; if (pe_cnt - pe0 != 1) begin errors++; $display("FAIL parity_bad_pulse: got %0d expected 1", pe_cnt - pe0); end
      checks++; if (pe_cyc != s + STOP_EDGE) begin errors++; $display("FAIL parity_bad_cycle: got %0d expected %0d", pe_cyc, s + STOP_EDGE); end
   endtask
`endif

   // Random frames with ready held high: every good frame must reach the
   // consumer in order, every low stop bit gives exactly one frame error.
   task automatic test_random;
      logic [7:0] exp_q[$];
      logic [7:0] b;
      logic bad, pf;
      int s, gap, fe0, ov0, exp_fe;
`ifdef UART_RX_PARITY_EN
      int pe0, exp_pe;
      pe0 = pe_cnt;
      exp_pe = 0;
`endif
      fe0 = fe_cnt;
      ov0 = ov_cnt;
      exp_fe = 0;
      acc_q.delete();
      rx_data_ready = 1'b1;
      for (int n = 0; n < 24; n++) begin
         b = 8'($urandom);
         bad = ($urandom_range(0, 5) == 0);
         pf = PAR_EN && ($urandom_range(0, 4) == 0);
         send_frame(b, !bad, pf, -10, s);
         if (bad) exp_fe++;
         else if (pf) begin
`ifdef UART_RX_PARITY_EN
            exp_pe++;
`endif
         end else exp_q.push_back(b);
         gap = bad ? $urandom_range(3, 12) : $urandom_range(0, 12);
         rx_pin = 1'b1;
         idle(gap);
      end
      idle(10);
      rx_data_ready = 1'b0;
      checks++; if (acc_q.size() != exp_q.size()) begin errors++; $display("FAIL random_count: got %0d bytes expected %0d", acc_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++) begin
         checks++; if (acc_q[i] !== exp_q[i]) begin errors++; $display("FAIL random_byte[%0d]: got %0h expected %0h", i, acc_q[i], exp_q[i]); end
      end
      checks++; if (fe_cnt - fe0 != exp_fe) begin errors++; $display("FAIL random_fe: got %0d expected %0d", fe_cnt - fe0, exp_fe); end
      checks++; if (ov_cnt != ov0) begin errors++; $display("FAIL random_overrun: got %0d expected 0", ov_cnt - ov0); end
`ifdef UART_RX_PARITY_EN
      checks++; if (pe_cnt - pe0 != exp_pe) begin errors++; $display("FAIL random_pe: got %0d expected %0d", pe_cnt - pe0, exp_pe); end
`endif
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_overrun();
      test_ready_on_delivery();
      test_frame_error();
      test_glitch();
      test_reset_mid();
`ifdef UART_RX_PARITY_EN
      test_parity();
`endif
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver, the receive-side counterpart of the SoC's `uart_tx`.
- Samples the asynchronous `rx_pin` with the system clock, recovers bytes LSB-first and presents each byte on a valid/ready handshake backed by a one-entry holding register.
- Sits beside `uart_tx` on the SoC bus so the CPU can read bytes received over the UART pin.

Parameters:
- UART_CLK_HZ, 27000000, system clock frequency in Hz.
- BAUD_RATE, 115200, line bit rate.
- Derived CLKS_PER_BIT = UART_CLK_HZ / BAUD_RATE, integer division truncated; 234 at defaults.
- Elaboration error if CLKS_PER_BIT < 4.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous active-high reset.
- rx_pin  input  1  asynchronous serial line; idle high.
- rx_data  output  8  received byte; stable while rx_data_valid=1.
- rx_data_valid  output  1  holding register full.
- rx_data_ready  input  1  consumer accepts; a transfer occurs when valid&ready are both 1 at a rising edge.
- frame_error  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: byte completed while the holding register was full and not being consumed.

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE, counters=0, rx_data=0, rx_data_valid=0, frame_error=0, overrun=0.
  - Both synchronizer flops set to 1.
  - Reset mid-frame abandons the frame; no pulse is emitted.
- Input path: 2-flop synchronizer. rx_s denotes the second flop's output. Detection latency is 2 cycles.
- Counter: bit_cnt, wide enough for CLKS_PER_BIT-1. bit_idx: 3 bits.
- State IDLE:
  - rx_s==0 -> START with bit_cnt=0.
- State START:
  - Increment bit_cnt. When bit_cnt == CLKS_PER_BIT/2 - 1, sample rx_s.
  - rx_s==0 -> DATA with bit_cnt=0, bit_idx=0.
  - rx_s==1 -> IDLE. Glitch rejected; no pulse.
- State DATA:
  - When bit_cnt == CLKS_PER_BIT-1, sample rx_s into the shift register at bit position bit_idx (LSB first).
  - Then reset bit_cnt to 0 and increment bit_idx.
  - After bit_idx==7 is sampled -> STOP.
- State STOP:
  - When bit_cnt == CLKS_PER_BIT-1, sample rx_s.
  - rx_s==1 -> IDLE; deliver the byte.
  - rx_s==0 -> assert frame_error for 1 cycle; discard the byte; -> BREAK.
- State BREAK:
  - Wait for rx_s==1, then -> IDLE. A held-low line produces exactly one frame_error.
- Delivery (on the edge where STOP samples rx_s==1):
  - Holding register empty, or being consumed this cycle (valid&ready) -> rx_data loads the byte; rx_data_valid=1 from the next cycle.
  - Holding register full and ready=0 -> new byte dropped; rx_data keeps the old byte; overrun=1 for 1 cycle.
- Consume: valid&ready with no simultaneous delivery -> rx_data_valid=0 the next cycle; rx_data holds its last value.
- rx_data_ready is ignored while rx_data_valid=0.
- Latency: rx_data_valid rises 1 cycle after the mid-stop-bit sample edge.
- Back-to-back frames: the receiver returns to IDLE at mid-stop-bit, so a start bit immediately following the stop bit is detected.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Frame is 8E1: one even-parity bit follows bit 7 and is sampled like a data bit (PARITY state, between DATA and STOP).
  - Extra output `parity_error` (1 bit): one-cycle pulse, asserted on the cycle the stop bit is sampled high, when XOR of the 8 data bits and the parity bit is 1.
  - A byte with a parity error is discarded and is not delivered.
  - The stop-bit check is unchanged.
- Undefined:
  - 8N1 only; no PARITY state.
  - `parity_error` port does not exist.

Test Plan:
- UART_CLK_HZ=1000000, BAUD_RATE=100000 (10 clks/bit): send 0xA5 8N1 with ready held 0 -> rx_data=0xA5; rx_data_valid=1 starting 1 cycle after the mid-stop sample; stays 1 until ready.
- Send 0x3C then 0xC3 back-to-back with ready=0 throughout -> rx_data stays 0x3C; overrun pulses once at the end of frame 2; rx_data_valid stays 1.
- Repeat the previous scenario but pulse ready=1 on the delivery cycle of 0xC3 -> rx_data=0xC3; valid stays 1; no overrun.
- Send 0x55 with the stop bit driven low, then hold the line low for 30 cycles, then high, then send 0x01 -> one frame_error pulse; 0x55 not delivered; 0x01 delivered.
- 3-cycle low glitch on an idle line -> no state exit beyond START, no valid, no pulses. Separately, assert rst mid-DATA of frame 0xFF -> all outputs 0; a following frame 0x81 is received correctly.
- With UART_RX_PARITY_EN: send 0x07 with parity bit 1 -> delivered 0x07. Send 0x07 with parity bit 0 -> parity_error pulse; rx_data_valid stays 0.
